// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA priority arbiter.
// Holds the arbiter state encoding and the priority-type selector values.
package dma_pkg;

  typedef enum logic [1:0] {
    SI   = 2'd0,
    SO   = 2'd1,
    SACT = 2'd2
  } arbState_t;

  localparam logic FIXED_PRIORITY    = 1'b0;
  localparam logic ROTATING_PRIORITY = 1'b1;

endpackage

// File: rtl/dma_priority_encoder.sv
// Find-first-set over req, scanning upward from start with wrap-around.
// Pure combinational; valid is low when no request bit is set.
module dma_priority_encoder #(
  parameter int NUM_CH = 4,
  localparam int W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [W-1:0]      start,
  output logic [W-1:0]      grant,
  output logic              valid
);

  always_comb begin
    int c;
    c     = 0;
    grant = '0;
    valid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = int'(start) + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!valid && req[c[W-1:0]]) begin
        valid = 1'b1;
        grant = c[W-1:0];
      end
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel priority arbiter: hold request, fixed/rotating grant, demand mode.
// Define DMA_DREQ_SYNC_EN to pass DREQ and EOP_N through a two-flop synchronizer.
module dma_priority_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int W = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic              priorityType,
  input  logic              controllerDisable,
  input  logic [NUM_CH-1:0] demandMode,
  input  logic              HLDA,
  input  logic              cycleDone,
  input  logic              EOP_N,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic [W-1:0]      activeChannel,
  output logic [NUM_CH-1:0] requestStatus
);

  localparam logic [W-1:0] LAST_CH = W'(NUM_CH - 1);

  logic [NUM_CH-1:0] dreqUse;
  logic              eopUse;

`ifdef DMA_DREQ_SYNC_EN
  logic [NUM_CH-1:0] dreqS1, dreqS2;
  logic              eopS1, eopS2;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      dreqS1 <= '0;
      dreqS2 <= '0;
      eopS1  <= 1'b1;
      eopS2  <= 1'b1;
    end else begin
      dreqS1 <= DREQ;
      dreqS2 <= dreqS1;
      eopS1  <= EOP_N;
      eopS2  <= eopS1;
    end
  end

  assign dreqUse = dreqS2;
  assign eopUse  = eopS2;
`else
  assign dreqUse = DREQ;
  assign eopUse  = EOP_N;
`endif

  arbState_t         state, stateNext;
  logic [W-1:0]      activeNext;
  logic [W-1:0]      lastServed, lastNext;
  logic [NUM_CH-1:0] pending;
  logic [W-1:0]      startIdx;
  logic [W-1:0]      winner;
  logic              winValid;
  logic              stayDemand;

  assign pending = dreqUse & ~maskReg;

  assign startIdx =
    (priorityType == FIXED_PRIORITY) ? '0 :
    (lastServed == LAST_CH) ? '0 :
    lastServed + 1'b1;

  dma_priority_encoder #(
    .NUM_CH(NUM_CH)
  ) uEnc (
    .req  (pending),
    .start(startIdx),
    .grant(winner),
    .valid(winValid)
  );

  // Demand mode keeps the frozen winner as long as it still requests.
  assign stayDemand = eopUse
    && demandMode[activeChannel]
    && dreqUse[activeChannel]
    && !maskReg[activeChannel];

  always_comb begin
    stateNext  = state;
    activeNext = activeChannel;
    lastNext   = lastServed;
    unique case (state)
      SI: begin
        if (|pending && !controllerDisable)
          stateNext = SO;
      end
      SO: begin
        if (!winValid) begin
          stateNext = SI;
        end else if (HLDA) begin
          stateNext  = SACT;
          activeNext = winner;
        end
      end
      SACT: begin
        if (!HLDA) begin
          stateNext = SI;
        end else if (cycleDone && !stayDemand) begin
          stateNext = SI;
          if (priorityType == ROTATING_PRIORITY)
            lastNext = activeChannel;
        end
      end
      default: stateNext = SI;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= SI;
      activeChannel <= '0;
      lastServed    <= LAST_CH;
      requestStatus <= '0;
    end else begin
      state         <= stateNext;
      activeChannel <= activeNext;
      lastServed    <= lastNext;
      requestStatus <= pending;
    end
  end

  assign HRQ = (state != SI);

  always_comb begin
    DACK = '0;
    DACK[activeChannel] = (state == SACT);
  end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed self-checking bench for dma_priority_arbiter, NUM_CH=4.
module tb_dma_priority_arbiter;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [3:0] DREQ;
  logic [3:0] maskReg;
  logic       priorityType;
  logic       controllerDisable;
  logic [3:0] demandMode;
  logic       HLDA;
  logic       cycleDone;
  logic       EOP_N;
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] activeChannel;
  logic [3:0] requestStatus;

  int checks = 0;
  int failures = 0;

  dma_priority_arbiter #(.NUM_CH(4)) dut (
    .CLK              (CLK),
    .RESET_N          (RESET_N),
    .DREQ             (DREQ),
    .maskReg          (maskReg),
    .priorityType     (priorityType),
    .controllerDisable(controllerDisable),
    .demandMode       (demandMode),
    .HLDA             (HLDA),
    .cycleDone        (cycleDone),
    .EOP_N            (EOP_N),
    .HRQ              (HRQ),
    .DACK             (DACK),
    .activeChannel    (activeChannel),
    .requestStatus    (requestStatus)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    DREQ = '0; maskReg = '0; priorityType = 1'b0;
    controllerDisable = 1'b0; demandMode = '0;
    HLDA = 1'b0; cycleDone = 1'b0; EOP_N = 1'b1;
    #3;
    checks++;
    if (HRQ !== 1'b0 || DACK !== 4'b0000) begin
      failures++;
      $display("FAIL reset_out HRQ=%b DACK=%b want 0 0000", HRQ, DACK);
    end
    checks++;
    if (activeChannel !== 2'd0 || requestStatus !== 4'b0000) begin
      failures++;
      $display("FAIL reset_idx act=%0d rs=%b want 0 0000",
               activeChannel, requestStatus);
    end
    step();
    RESET_N = 1'b1;
    step();
  endtask

  task automatic test_fixed();
    priorityType = 1'b0;
    DREQ = 4'b1010;
    step();
    checks++;
    if (HRQ !== 1'b1 || DACK !== 4'b0000) begin
      failures++;
      $display("FAIL fixed_so HRQ=%b DACK=%b want 1 0000", HRQ, DACK);
    end
    checks++;
    if (requestStatus !== 4'b1010) begin
      failures++;
      $display("FAIL req_status got=%b want 1010", requestStatus);
    end
    HLDA = 1'b1;
    step();
    checks++;
    if (DACK !== 4'b0010 || activeChannel !== 2'd1) begin
      failures++;
      $display("FAIL fixed_grant DACK=%b act=%0d want 0010 1",
               DACK, activeChannel);
    end
    DREQ = 4'b0001;
    step();
    checks++;
    if (DACK !== 4'b0010) begin
      failures++;
      $display("FAIL frozen DACK=%b want 0010", DACK);
    end
    cycleDone = 1'b1;
    step();
    cycleDone = 1'b0;
    HLDA = 1'b0;
    DREQ = '0;
    checks++;
    if (DACK !== 4'b0000 || HRQ !== 1'b0) begin
      failures++;
      $display("FAIL fixed_rel DACK=%b HRQ=%b want 0000 0", DACK, HRQ);
    end
    step();
  endtask

  task automatic test_rotating();
    priorityType = 1'b1;
    DREQ = 4'b0010;
    step();
    HLDA = 1'b1;
    step();
    checks++;
    if (DACK !== 4'b0010) begin
      failures++;
      $display("FAIL rot_ch1 DACK=%b want 0010", DACK);
    end
    cycleDone = 1'b1;
    DREQ = 4'b0011;
    step();
    cycleDone = 1'b0;
    HLDA = 1'b0;
    checks++;
    if (HRQ !== 1'b0 || DACK !== 4'b0000) begin
      failures++;
      $display("FAIL rot_gap HRQ=%b DACK=%b want 0 0000", HRQ, DACK);
    end
    step();
    checks++;
    if (HRQ !== 1'b1) begin
      failures++;
      $display("FAIL rot_rearb HRQ=%b want 1", HRQ);
    end
    HLDA = 1'b1;
    step();
    checks++;
    if (DACK !== 4'b0001 || activeChannel !== 2'd0) begin
      failures++;
      $display("FAIL rot_wrap DACK=%b act=%0d want 0001 0",
               DACK, activeChannel);
    end
    EOP_N = 1'b0;
    cycleDone = 1'b1;
    step();
    EOP_N = 1'b1;
    cycleDone = 1'b0;
    HLDA = 1'b0;
    DREQ = '0;
    step();
  endtask

  task automatic test_demand();
    priorityType = 1'b0;
    demandMode = 4'b0100;
    DREQ = 4'b0100;
    step();
    HLDA = 1'b1;
    step();
    for (int p = 1; p <= 3; p++) begin
      cycleDone = 1'b1;
      if (p == 3) EOP_N = 1'b0;
      step();
      cycleDone = 1'b0;
      EOP_N = 1'b1;
      checks++;
      if (p < 3 && DACK !== 4'b0100) begin
        failures++;
        $display("FAIL demand_hold p=%0d DACK=%b want 0100", p, DACK);
      end else if (p == 3 && (DACK !== 4'b0000 || HRQ !== 1'b0)) begin
        failures++;
        $display("FAIL demand_eop DACK=%b HRQ=%b want 0000 0", DACK, HRQ);
      end
      if (p < 3) step();
    end
    demandMode = '0;
    HLDA = 1'b0;
    DREQ = '0;
    step();
  endtask

  task automatic test_withdraw();
    DREQ = 4'b0001;
    step();
    checks++;
    if (HRQ !== 1'b1) begin
      failures++;
      $display("FAIL wd_hrq HRQ=%b want 1", HRQ);
    end
    DREQ = 4'b0000;
    step();
    checks++;
    if (HRQ !== 1'b0 || DACK !== 4'b0000) begin
      failures++;
      $display("FAIL wd_drop HRQ=%b DACK=%b want 0 0000", HRQ, DACK);
    end
    HLDA = 1'b1;
    step();
    checks++;
    if (DACK !== 4'b0000) begin
      failures++;
      $display("FAIL wd_nodack DACK=%b want 0000", DACK);
    end
    HLDA = 1'b0;
    step();
  endtask

  task automatic test_disable();
    controllerDisable = 1'b1;
    DREQ = 4'b0100;
    step();
    checks++;
    if (HRQ !== 1'b0) begin
      failures++;
      $display("FAIL dis_idle HRQ=%b want 0", HRQ);
    end
    controllerDisable = 1'b0;
    step();
    controllerDisable = 1'b1;
    HLDA = 1'b1;
    step();
    checks++;
    if (DACK !== 4'b0100) begin
      failures++;
      $display("FAIL dis_inflight DACK=%b want 0100", DACK);
    end
    controllerDisable = 1'b0;
    cycleDone = 1'b1;
    step();
    cycleDone = 1'b0;
    HLDA = 1'b0;
    DREQ = '0;
    step();
  endtask

  task automatic test_abort();
    // lastServed is ch0 here; rotating start is ch1.
    priorityType = 1'b1;
    DREQ = 4'b1000;
    step();
    HLDA = 1'b1;
    step();
    checks++;
    if (DACK !== 4'b1000) begin
      failures++;
      $display("FAIL abort_grant DACK=%b want 1000", DACK);
    end
    HLDA = 1'b0;
    cycleDone = 1'b1;
    step();
    cycleDone = 1'b0;
    checks++;
    if (DACK !== 4'b0000 || HRQ !== 1'b0) begin
      failures++;
      $display("FAIL abort_drop DACK=%b HRQ=%b want 0000 0", DACK, HRQ);
    end
    DREQ = 4'b1001;
    step();
    HLDA = 1'b1;
    step();
    checks++;
    if (DACK !== 4'b1000) begin
      failures++;
      $display("FAIL abort_ptr DACK=%b want 1000", DACK);
    end
  endtask

  task automatic test_reset_mid();
    #2;
    RESET_N = 1'b0;
    #1;
    checks++;
    if (HRQ !== 1'b0 || DACK !== 4'b0000) begin
      failures++;
      $display("FAIL rst_mid HRQ=%b DACK=%b want 0 0000", HRQ, DACK);
    end
    checks++;
    if (activeChannel !== 2'd0 || requestStatus !== 4'b0000) begin
      failures++;
      $display("FAIL rst_mid_idx act=%0d rs=%b want 0 0000",
               activeChannel, requestStatus);
    end
    step();
    DREQ = '0;
    RESET_N = 1'b1;
    step();
    checks++;
    if (DACK !== 4'b0000 || HRQ !== 1'b0) begin
      failures++;
      $display("FAIL rst_after DACK=%b HRQ=%b want 0000 0", DACK, HRQ);
    end
    HLDA = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rotating();
    test_demand();
    test_withdraw();
    test_disable();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
